// File: rtl/q_table_update.sv
// q_table_update: owns the N_STATES x N_ACTIONS Q-table and applies one
// temporal-difference update per request:
//   Q(s,a) <= Q(s,a) + lr*(reward + gamma*max_q - Q(s,a))
// A single shared multiplier is time-multiplexed between the discount
// product (DISC) and the learning-rate product (SCALE). Q values are Q16.16.
module q_table_update #(
    parameter int N_STATES  = 36,
    parameter int N_ACTIONS = 4,
    parameter int QW        = 32,
    parameter int FRAC      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_table,
    input  logic                 start,
    input  logic [5:0]           state_in,
    input  logic [2:0]           action_in,
    input  logic [3:0]           reward,
    input  logic signed [QW-1:0] max_q,
    input  logic [15:0]          learn_rate,
    input  logic [15:0]          discount,
    output logic signed [QW-1:0] q_out [N_STATES][N_ACTIONS],
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    // TD error and scaled delta need two extra bits beyond QW.
    localparam int TDW = QW + 2;
    // Multiplier: 17-bit signed (zero-extended Q0.16 coefficient) x TDW signed.
    localparam int MAW = 17;
    localparam int PW  = MAW + TDW;
    localparam int AW  = (N_ACTIONS > 1) ? $clog2(N_ACTIONS) : 1;
    localparam logic [5:0] S_LIM = 6'(N_STATES);
    localparam logic [2:0] A_LIM = 3'(N_ACTIONS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DISC  = 3'd2,
        TD    = 3'd3,
        SCALE = 3'd4,
        WRITE = 3'd5
    } state_t;

    state_t state, state_nxt;

    // Request captured at start; later input changes do not disturb it.
    logic [5:0]           state_p0;
    logic [2:0]           action_p0;
    logic [3:0]           reward_p0;
    logic signed [QW-1:0] max_q_p0;
    logic [15:0]          lr_p0;
    logic [15:0]          gamma_p0;

    // Per-stage working values.
    logic                  err_p1;
    logic signed [QW-1:0]  q0_p1;
    logic signed [QW-1:0]  t_p2;
    logic signed [TDW-1:0] td_p3;
    logic signed [TDW-1:0] d_p4;

    logic                  addr_ok;
    logic [AW-1:0]         col;
    logic signed [MAW-1:0] mul_a;
    logic signed [TDW-1:0] mul_b;
    logic signed [PW-1:0]  mul_p;
    logic signed [TDW:0]   sum_q;
    logic                  mul_unused;
    logic                  take;

    // Saturate a wide signed sum into the QW-bit Q range.
    function automatic logic signed [QW-1:0] sat_q(input logic signed [TDW:0] v);
        logic [TDW-QW+1:0] top;
        top = v[TDW:QW-1];
        if (top == '0 || top == '1)
            return v[QW-1:0];
        else if (v[TDW])
            return {1'b1, {(QW-1){1'b0}}};
        else
            return {1'b0, {(QW-1){1'b1}}};
    endfunction

    assign addr_ok = (state_p0 < S_LIM) && (action_p0 != 3'd0) && (action_p0 <= A_LIM);
    assign col     = AW'(action_p0 - 3'd1);
    assign busy    = (state != IDLE);
    assign take    = (state == IDLE) && start && !clear_table;
    assign sum_q   = (TDW+1)'(q0_p1) + (TDW+1)'(d_p4);

    // Shared multiplier: gamma*max_q during DISC, lr*td during SCALE.
    always_comb begin
        mul_a = $signed({1'b0, gamma_p0});
        mul_b = $signed({{(TDW-QW){max_q_p0[QW-1]}}, max_q_p0});
        if (state == SCALE) begin
            mul_a = $signed({1'b0, lr_p0});
            mul_b = td_p3;
        end
        mul_p = PW'(mul_a) * PW'(mul_b);
    end

    // Product bits below the binary point and the spare top bit are dropped.
    assign mul_unused = ^{mul_p[PW-1:FRAC+TDW], mul_p[FRAC-1:0]};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; an invalid address skips the arithmetic and goes to WRITE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = READ;
            READ:    state_nxt = DISC;
            DISC:    state_nxt = err_p1 ? WRITE : TD;
            TD:      state_nxt = SCALE;
            SCALE:   state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control flags: address-check result and the done/err pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_p1 <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (state == READ)
                err_p1 <= !addr_ok;
            done <= (state == WRITE);
            err  <= (state == WRITE) && err_p1;
        end
    end

    // Datapath registers: input capture and per-stage arithmetic.
    always_ff @(posedge clk) begin
        if (take) begin
            state_p0  <= state_in;
            action_p0 <= action_in;
            reward_p0 <= reward;
            max_q_p0  <= max_q;
            lr_p0     <= learn_rate;
            gamma_p0  <= discount;
        end
        // READ -> DISC: fetch current Q(s,a)
        if (state == READ)
            q0_p1 <= addr_ok ? q_out[state_p0][col] : '0;
        // DISC -> TD: t = (gamma*max_q) >>> FRAC
        if (state == DISC)
            t_p2 <= mul_p[FRAC +: QW];
        // TD -> SCALE: td = reward<<FRAC + t - q0
        if (state == TD)
            td_p3 <= $signed({{(TDW-4-FRAC){1'b0}}, reward_p0, {FRAC{1'b0}}})
                     + TDW'(t_p2) - TDW'(q0_p1);
        // SCALE -> WRITE: d = (lr*td) >>> FRAC
        if (state == SCALE)
            d_p4 <= mul_p[FRAC +: TDW];
    end

    // Q-table storage: reset/clear zero everything, WRITE updates one entry.
    always_ff @(posedge clk) begin
        if (reset || (state == IDLE && clear_table)) begin
            for (int i = 0; i < N_STATES; i++)
                for (int j = 0; j < N_ACTIONS; j++)
                    q_out[i][j] <= '0;
        end else if (state == WRITE && !err_p1) begin
            q_out[state_p0][col] <= sat_q(sum_q);
        end
    end

endmodule

// File: tb/tb_q_table_update.sv
// Testbench for q_table_update: directed scenarios plus randomized requests,
// checked against a plain-arithmetic Q-learning reference model.
module tb_q_table_update;

    logic               clk = 1'b0;
    logic               reset;
    logic               clear_table;
    logic               start;
    logic [5:0]         state_in;
    logic [2:0]         action_in;
    logic [3:0]         reward;
    logic signed [31:0] max_q;
    logic [15:0]        learn_rate;
    logic [15:0]        discount;
    logic signed [31:0] q_out [36][4];
    logic               busy;
    logic               done;
    logic               err;

    int n_tests = 0;
    int n_fail  = 0;
    longint mdl [36][4];

    q_table_update dut (
        .clk(clk), .reset(reset), .clear_table(clear_table), .start(start),
        .state_in(state_in), .action_in(action_in), .reward(reward),
        .max_q(max_q), .learn_rate(learn_rate), .discount(discount),
        .q_out(q_out), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference: Q + lr*(r + gamma*maxq - Q) in Q16.16 with floor shifts and saturation.
    function automatic longint td_update(longint q0, longint r, longint mq, longint lr, longint g);
        longint t, td, d, s;
        t  = (g * mq) >>> 16;
        td = r * 65536 + t - q0;
        d  = (lr * td) >>> 16;
        s  = q0 + d;
        if (s > 64'sd2147483647)  s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        return s;
    endfunction

    function automatic bit req_ok(input int s, input int a);
        return (s < 36) && (a >= 1) && (a <= 4);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 36; i++)
            for (int j = 0; j < 4; j++)
                mdl[i][j] = 0;
    endtask

    task automatic cmp_table(input string tag);
        for (int i = 0; i < 36; i++)
            for (int j = 0; j < 4; j++)
                chk(tag, q_out[i][j], 32'(mdl[i][j]));
    endtask

    // Drive a request; returns #1 after the sampling edge with inputs scrambled.
    task automatic send(input int s, input int a, input int r, input logic signed [31:0] mq,
                        input int lr, input int g);
        state_in   = 6'(s);
        action_in  = 3'(a);
        reward     = 4'(r);
        max_q      = mq;
        learn_rate = 16'(lr);
        discount   = 16'(g);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        state_in   = 6'($urandom);
        action_in  = 3'($urandom);
        reward     = 4'($urandom);
        max_q      = $urandom;
        learn_rate = 16'($urandom);
        discount   = 16'($urandom);
        if (req_ok(s, a))
            mdl[s][a-1] = td_update(mdl[s][a-1], r, longint'(mq), lr, g);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 20);
    endtask

    // Full request: send, check busy, latency, err and the whole table.
    task automatic req(input string tag, input int s, input int a, input int r,
                       input logic signed [31:0] mq, input int lr, input int g);
        int  n;
        bit  ok;
        ok = req_ok(s, a);
        send(s, a, r, mq, lr, g);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(n);
        chk({tag, "_lat"}, n, ok ? 32'd5 : 32'd3);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_err"}, 32'(err), ok ? 32'd0 : 32'd1);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        cmp_table({tag, "_tbl"});
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
    endtask

    initial begin
        int cnt, first, n;
        reset = 1'b1; clear_table = 1'b0; start = 1'b0;
        state_in = '0; action_in = '0; reward = '0; max_q = '0;
        learn_rate = '0; discount = '0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err",  32'(err),  32'd0);
        cmp_table("rst_tbl");

        // Goal update and discount path
        req("goal", 35, 2, 10, 32'sh0, 16'h8000, 16'hE666);
        chk("goal_val", q_out[35][1], 32'h0005_0000);
        @(negedge clk);
        req("disc", 0, 1, 0, 32'sh0001_0000, 16'h8000, 16'h8000);
        chk("disc_val", q_out[0][0], 32'h0000_4000);

        // Positive saturation, then negative saturation
        @(negedge clk);
        req("satp1", 30, 1, 15, 32'sh7FFF_FFFF, 16'hFFFF, 16'hFFFF);
        @(negedge clk);
        req("satp2", 30, 1, 15, 32'sh7FFF_FFFF, 16'hFFFF, 16'hFFFF);
        chk("satp_val", q_out[30][0], 32'h7FFF_FFFF);
        @(negedge clk);
        req("satn", 30, 1, 0, 32'sh8000_0000, 16'hFFFF, 16'hFFFF);
        @(negedge clk);
        req("satn2", 30, 1, 0, 32'sh8000_0000, 16'hFFFF, 16'hFFFF);

        // Bad requests leave the table untouched
        @(negedge clk);
        req("bad_a0", 5, 0, 3, 32'sh0001_0000, 16'h8000, 16'h8000);
        @(negedge clk);
        req("bad_a5", 5, 5, 3, 32'sh0001_0000, 16'h8000, 16'h8000);
        @(negedge clk);
        req("bad_s36", 36, 1, 3, 32'sh0001_0000, 16'h8000, 16'h8000);

        // start while busy is ignored
        @(negedge clk);
        send(7, 3, 4, 32'sh0002_0000, 16'h4000, 16'hC000);
        @(negedge clk);
        state_in = 6'd8; action_in = 3'd1; reward = 4'd9;
        learn_rate = 16'hFFFF; discount = 16'hFFFF; max_q = 32'sh0010_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        first = 0; cnt = 0;
        for (int i = 2; i <= 14; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cnt++;
                if (first == 0) first = i;
            end
        end
        chk("busy_ndone", cnt, 32'd1);
        chk("busy_lat", first, 32'd5);
        cmp_table("busy_tbl");

        // start in the done cycle is accepted
        @(negedge clk);
        send(9, 4, 2, 32'sh0003_0000, 16'h2000, 16'h9000);
        wait_done(n);
        chk("dc_lat1", n, 32'd5);
        send(9, 4, 6, 32'shFFFE_0000, 16'hA000, 16'h7000);
        chk("dc_busy", 32'(busy), 32'd1);
        wait_done(n);
        chk("dc_lat2", n, 32'd5);
        cmp_table("dc_tbl");

        // Reset asserted while in TD
        @(negedge clk);
        send(11, 2, 5, 32'sh0001_0000, 16'h8000, 16'h8000);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
        chk("rtd_busy", 32'(busy), 32'd0);
        count_dones(10, cnt);
        chk("rtd_ndone", cnt, 32'd0);
        cmp_table("rtd_tbl");

        // clear_table with start in IDLE: clear wins
        @(negedge clk);
        req("pre_clr", 12, 3, 7, 32'sh0004_0000, 16'hC000, 16'hC000);
        @(negedge clk);
        state_in = 6'd13; action_in = 3'd2; reward = 4'd8;
        max_q = 32'sh0001_0000; learn_rate = 16'h8000; discount = 16'h8000;
        clear_table = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        clear_table = 1'b0;
        start = 1'b0;
        clear_model();
        chk("clr_busy", 32'(busy), 32'd0);
        count_dones(10, cnt);
        chk("clr_ndone", cnt, 32'd0);
        cmp_table("clr_tbl");

        // Randomized requests, including invalid addresses, with occasional clears
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) begin
                clear_table = 1'b1;
                @(posedge clk);
                #1;
                clear_table = 1'b0;
                clear_model();
                cmp_table("rnd_clr");
                @(negedge clk);
            end
            req("rnd", int'($urandom_range(0, 38)), int'($urandom_range(0, 6)),
                int'($urandom_range(0, 15)), $urandom,
                int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
